// File: rtl/data_memory_lsu_if.sv
// ---------------------------------------------------------------------------
// data_memory_lsu_if
// Request/response bundle between the core execute stage (master) and the
// data-memory load/store unit (slave).
//   req_valid  m->s  request present
//   req_ready  s->m  unit can accept a request this cycle
//   we         m->s  1 = store, 0 = load
//   addr       m->s  byte address
//   funct3     m->s  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
//   wd         m->s  store data, right-aligned
//   rsp_valid  s->m  one-cycle response pulse
//   rd         s->m  load result (0 for stores and errors)
//   err        s->m  illegal funct3 flag, qualifies rsp_valid
//   misaligned s->m  access crossed a word boundary, qualifies rsp_valid
// ---------------------------------------------------------------------------
interface data_memory_lsu_if #(
  parameter int ADDR_W = 32
) ();
  logic              req_valid;
  logic              req_ready;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [2:0]        funct3;
  logic [31:0]       wd;
  logic              rsp_valid;
  logic [31:0]       rd;
  logic              err;
  logic              misaligned;

  modport master (
    output req_valid, we, addr, funct3, wd,
    input  req_ready, rsp_valid, rd, err, misaligned
  );

  modport slave (
    input  req_valid, we, addr, funct3, wd,
    output req_ready, rsp_valid, rd, err, misaligned
  );
endinterface

// File: rtl/data_memory_lsu.sv
// ---------------------------------------------------------------------------
// data_memory_lsu
// Byte-addressed RV32 load/store unit around a word-organised RAM.
// Aligned accesses complete in one cycle; accesses that cross a word boundary
// are split into two word beats (IDLE -> BEAT2) with req_ready low in BEAT2.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset (memory contents are kept)
//   bus  data_memory_lsu_if.slave: valid/ready request, registered response
// ---------------------------------------------------------------------------
module data_memory_lsu #(
  parameter int DEPTH        = 1024,
  parameter int ADDR_W       = 32,
  parameter int INIT_PATTERN = 1
) (
  input logic              clk,
  input logic              rst,
  data_memory_lsu_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  typedef enum logic {ST_IDLE = 1'b0, ST_BEAT2 = 1'b1} state_e;

  // funct3 values with no defined access size
  function automatic logic illegal_f(input logic [2:0] f3);
    case (f3)
      3'b011, 3'b110, 3'b111: illegal_f = 1'b1;
      default:                illegal_f = 1'b0;
    endcase
  endfunction

  // Byte-lane mask of an access starting at lane 0
  function automatic logic [3:0] size_mask_f(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: size_mask_f = 4'b0001;
      3'b001, 3'b101: size_mask_f = 4'b0011;
      default:        size_mask_f = 4'b1111;
    endcase
  endfunction

  // True when off + size runs past the end of the word
  function automatic logic crosses_f(input logic [1:0] off, input logic [2:0] f3);
    logic [2:0] size;
    case (f3)
      3'b000, 3'b100: size = 3'd1;
      3'b001, 3'b101: size = 3'd2;
      default:        size = 3'd4;
    endcase
    crosses_f = (({1'b0, off} + size) > 3'd4);
  endfunction

  // Sign/zero extension of the right-aligned load bytes
  function automatic logic [31:0] extend_f(input logic [31:0] raw, input logic [2:0] f3);
    case (f3)
      3'b000:  extend_f = {{24{raw[7]}}, raw[7:0]};
      3'b001:  extend_f = {{16{raw[15]}}, raw[15:0]};
      3'b100:  extend_f = {24'd0, raw[7:0]};
      3'b101:  extend_f = {16'd0, raw[15:0]};
      default: extend_f = raw;
    endcase
  endfunction

  state_e           state_q, state_d;
  logic             we_q;
  logic [1:0]       off_q;
  logic [2:0]       f3_q;
  logic [31:0]      wd_q;
  logic [IDX_W-1:0] widx_q;
  logic [31:0]      first_q;
  logic             rsp_valid_q, err_q, mis_q;
  logic [31:0]      rd_q;

  logic             accept_s, req_ready_s, capture_s;
  logic [1:0]       in_off_s, sel_off_s;
  logic [IDX_W-1:0] in_widx_s, nxt_widx_s;
  logic [2:0]       sel_f3_s;
  logic [31:0]      sel_wd_s, win_lo_s, win_hi_s, win_s;
  logic [63:0]      lane_data_s;
  logic [7:0]       lane_be_s;
  logic             wr_en_s;
  logic [IDX_W-1:0] wr_idx_s;
  logic [3:0]       wr_be_s;
  logic [31:0]      wr_data_s;
  logic             rsp_fire_d, err_d, mis_d;
  logic [31:0]      rd_d;
  logic [31:0]      mem_rd_s [DEPTH];
  logic             unused_addr_s;

  assign in_off_s      = bus.addr[1:0];
  assign in_widx_s     = bus.addr[IDX_W+1:2];
  assign nxt_widx_s    = widx_q + IDX_ONE;   // natural wrap DEPTH-1 -> 0
  assign unused_addr_s = ^bus.addr[ADDR_W-1:IDX_W+2];
  assign accept_s      = bus.req_valid && (state_q == ST_IDLE);

  // In IDLE the live request drives the datapath, in BEAT2 the captured one
  assign sel_off_s = (state_q == ST_IDLE) ? in_off_s   : off_q;
  assign sel_f3_s  = (state_q == ST_IDLE) ? bus.funct3 : f3_q;
  assign sel_wd_s  = (state_q == ST_IDLE) ? bus.wd     : wd_q;

  // Two-word window: low word is the first beat, high word the second beat
  assign win_lo_s    = (state_q == ST_IDLE) ? mem_rd_s[in_widx_s] : first_q;
  assign win_hi_s    = (state_q == ST_IDLE) ? 32'd0 : mem_rd_s[nxt_widx_s];
  assign win_s       = 32'({win_hi_s, win_lo_s} >> {sel_off_s, 3'b000});
  assign lane_data_s = {32'd0, sel_wd_s} << {sel_off_s, 3'b000};
  assign lane_be_s   = {4'd0, size_mask_f(sel_f3_s)} << sel_off_s;

  // Word storage; contents survive rst, optional index pattern at time zero
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
    logic [31:0] word_q = (INIT_PATTERN != 0) ? 32'(gi) : 32'd0;

    // Byte-lane write of this word
    always_ff @(posedge clk) begin
      if (wr_en_s && (wr_idx_s == IDX_W'(gi))) begin
        for (int b = 0; b < 4; b++) begin
          if (wr_be_s[b]) begin
            word_q[8*b +: 8] <= wr_data_s[8*b +: 8];
          end
        end
      end
    end

    assign mem_rd_s[gi] = word_q;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s && !illegal_f(bus.funct3) && crosses_f(in_off_s, bus.funct3)) begin
          state_d = ST_BEAT2;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BEAT2: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: ready, memory write port and next response values
  always_comb begin
    req_ready_s = (state_q == ST_IDLE);
    capture_s   = 1'b0;
    wr_en_s     = 1'b0;
    wr_idx_s    = in_widx_s;
    wr_be_s     = 4'd0;
    wr_data_s   = 32'd0;
    rsp_fire_d  = 1'b0;
    rd_d        = rd_q;
    err_d       = err_q;
    mis_d       = mis_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          capture_s = 1'b1;
          if (illegal_f(bus.funct3)) begin
            rsp_fire_d = 1'b1;
            rd_d       = 32'd0;
            err_d      = 1'b1;
            mis_d      = 1'b0;
          end else begin
            // rst wins over a same-cycle acceptance: no write
            wr_en_s   = bus.we && !rst;
            wr_be_s   = lane_be_s[3:0];
            wr_data_s = lane_data_s[31:0];
            if (crosses_f(in_off_s, bus.funct3)) begin
              rsp_fire_d = 1'b0;
            end else begin
              rsp_fire_d = 1'b1;
              rd_d       = bus.we ? 32'd0 : extend_f(win_s, bus.funct3);
              err_d      = 1'b0;
              mis_d      = 1'b0;
            end
          end
        end else begin
          capture_s = 1'b0;
        end
      end
      ST_BEAT2: begin
        wr_en_s    = we_q && !rst;
        wr_idx_s   = nxt_widx_s;
        wr_be_s    = lane_be_s[7:4];
        wr_data_s  = lane_data_s[63:32];
        rsp_fire_d = 1'b1;
        rd_d       = we_q ? 32'd0 : extend_f(win_s, f3_q);
        err_d      = 1'b0;
        mis_d      = 1'b1;
      end
      default: begin
        req_ready_s = 1'b0;
      end
    endcase
  end

  // Request capture and registered response
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q        <= 1'b0;
      off_q       <= 2'd0;
      f3_q        <= 3'd0;
      wd_q        <= 32'd0;
      widx_q      <= '0;
      first_q     <= 32'd0;
      rsp_valid_q <= 1'b0;
      rd_q        <= 32'd0;
      err_q       <= 1'b0;
      mis_q       <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_fire_d;
      rd_q        <= rd_d;
      err_q       <= err_d;
      mis_q       <= mis_d;
      if (capture_s) begin
        we_q    <= bus.we;
        off_q   <= in_off_s;
        f3_q    <= bus.funct3;
        wd_q    <= bus.wd;
        widx_q  <= in_widx_s;
        first_q <= mem_rd_s[in_widx_s];
      end
    end
  end

  assign bus.req_ready  = req_ready_s;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rd         = rd_q;
  assign bus.err        = err_q;
  assign bus.misaligned = mis_q;
endmodule
